// File: rtl/img_pkg.sv
// Shared types for the sliding-window line buffer.
// Read-side FSM states and slot-ring arithmetic.
package img_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH
  } rd_state_e;

  function automatic int slot_add(
    input int base,
    input int off,
    input int n
  );
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/window_line_buffer_if.sv
// Pixel-in / window-out handshake bundle.
// slave = line buffer view, master = source/sink view.
interface window_line_buffer_if #(
  parameter int PIXEL_W = 8,
  parameter int K       = 3
);
  logic [PIXEL_W-1:0]     pixel_data;
  logic                   pixel_data_valid;
  logic                   pixel_ready;
  logic [K*K*PIXEL_W-1:0] window_data;
  logic                   window_valid;
  logic                   out_ready;
  logic                   intr;
  logic                   frame_done;

  modport slave (
    input  pixel_data,
    input  pixel_data_valid,
    input  out_ready,
    output pixel_ready,
    output window_data,
    output window_valid,
    output intr,
    output frame_done
  );

  modport master (
    output pixel_data,
    output pixel_data_valid,
    output out_ready,
    input  pixel_ready,
    input  window_data,
    input  window_valid,
    input  intr,
    input  frame_done
  );
endinterface

// File: rtl/line_buffer_ram.sv
// One image row: registered write, combinational
// read of K adjacent pixels starting at i_rcol.
module line_buffer_ram #(
  parameter int PIXEL_W = 8,
  parameter int IMG_W   = 512,
  parameter int K       = 3
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [PIXEL_W-1:0]         i_wdata,
  input  logic [$clog2(IMG_W)-1:0]   i_wcol,
  input  logic [$clog2(IMG_W)-1:0]   i_rcol,
  output logic [K*PIXEL_W-1:0]       o_rdata
);
  localparam int CW = $clog2(IMG_W);

  logic [PIXEL_W-1:0] mem_q [IMG_W];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_wcol] <= i_wdata;
  end

  always_comb begin
    o_rdata = '0;
    for (int j = 0; j < K; j++) begin
      o_rdata[j*PIXEL_W +: PIXEL_W] = mem_q[i_rcol + CW'(j)];
    end
  end
endmodule

// File: rtl/window_line_buffer.sv
// Raster stream in, KxK sliding windows out with back-pressure.
// K+1 row slots rotate; one frame yields IMG_H-K+1 window rows.
module window_line_buffer
  import img_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int IMG_W   = 512,
  parameter int IMG_H   = 512,
  parameter int K       = 3
) (
  input logic i_clk,
  input logic i_rst,
  window_line_buffer_if.slave bus
);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H + 1);
  localparam int SLOT_W = $clog2(K + 1);
  localparam int FULL_W = $clog2(K + 2);
  localparam int NS     = K + 1;
  localparam int LINE_W = K * PIXEL_W;
  localparam int WIN_W  = K * K * PIXEL_W;

  logic [COL_W-1:0]  col_wr_q, col_wr_d;
  logic [COL_W-1:0]  col_rd_q, col_rd_d;
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
  logic [FULL_W-1:0] rows_full_q, rows_full_d;
  logic [ROW_W-1:0]  rows_wr_q, rows_wr_d;
  logic [ROW_W-1:0]  rows_rd_q, rows_rd_d;
  rd_state_e         state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              intr_q, intr_d;
  logic              done_q, done_d;

  logic              wr_fire, wr_eol;
  logic              load, rd_eol, flush_done;
  logic [LINE_W-1:0] rd_line [NS];
  logic [WIN_W-1:0]  win_mux;

  assign bus.pixel_ready = (rows_full_q < FULL_W'(NS))
                        && (rows_wr_q < ROW_W'(IMG_H));
  assign wr_fire = bus.pixel_data_valid & bus.pixel_ready;
  assign wr_eol  = wr_fire && (col_wr_q == COL_W'(IMG_W - 1));
  assign load    = (state_q == READ) && (!valid_q || bus.out_ready);
  assign rd_eol  = load && (col_rd_q == COL_W'(IMG_W - K));
  assign flush_done = (state_q == FLUSH) && (!valid_q || bus.out_ready);

  for (genvar s = 0; s < NS; s++) begin : g_slot
    line_buffer_ram #(
      .PIXEL_W(PIXEL_W),
      .IMG_W  (IMG_W),
      .K      (K)
    ) u_ram (
      .i_clk  (i_clk),
      .i_we   (wr_fire && (wr_slot_q == SLOT_W'(s))),
      .i_wdata(bus.pixel_data),
      .i_wcol (col_wr_q),
      .i_rcol (col_rd_q),
      .o_rdata(rd_line[s])
    );
  end

  // window row 0 is the oldest stored row, at rd_slot
  always_comb begin
    win_mux = '0;
    for (int r = 0; r < K; r++) begin
      win_mux[r*LINE_W +: LINE_W] =
        rd_line[SLOT_W'(slot_add(int'(rd_slot_q), r, NS))];
    end
  end

  always_comb begin
    col_wr_d    = col_wr_q;
    col_rd_d    = col_rd_q;
    wr_slot_d   = wr_slot_q;
    rd_slot_d   = rd_slot_q;
    rows_wr_d   = rows_wr_q;
    rows_rd_d   = rows_rd_q;
    state_d     = state_q;
    win_d       = win_q;
    valid_d     = valid_q;
    last_d      = last_q;
    intr_d      = valid_q && bus.out_ready && last_q;
    done_d      = flush_done;
    rows_full_d = rows_full_q + FULL_W'(wr_eol) - FULL_W'(rd_eol);

    if (wr_fire) begin
      col_wr_d = wr_eol ? '0 : col_wr_q + 1'b1;
    end
    if (wr_eol) begin
      wr_slot_d = SLOT_W'(slot_add(int'(wr_slot_q), 1, NS));
      rows_wr_d = rows_wr_q + 1'b1;
    end

    if (load) begin
      win_d    = win_mux;
      valid_d  = 1'b1;
      last_d   = rd_eol;
      col_rd_d = rd_eol ? '0 : col_rd_q + 1'b1;
    end else if (bus.out_ready) begin
      valid_d  = 1'b0;
    end
    if (rd_eol) begin
      rd_slot_d = SLOT_W'(slot_add(int'(rd_slot_q), 1, NS));
      rows_rd_d = rows_rd_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (rows_full_q >= FULL_W'(K)) state_d = READ;
      end
      READ: begin
        if (rd_eol) begin
          state_d = (rows_rd_q == ROW_W'(IMG_H - K)) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        // leftover K-1 rows are dropped with the counters
        if (flush_done) begin
          state_d     = IDLE;
          col_wr_d    = '0;
          col_rd_d    = '0;
          wr_slot_d   = '0;
          rd_slot_d   = '0;
          rows_wr_d   = '0;
          rows_rd_d   = '0;
          rows_full_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_wr_q    <= '0;
      col_rd_q    <= '0;
      wr_slot_q   <= '0;
      rd_slot_q   <= '0;
      rows_full_q <= '0;
      rows_wr_q   <= '0;
      rows_rd_q   <= '0;
      state_q     <= IDLE;
      win_q       <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      intr_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      col_wr_q    <= col_wr_d;
      col_rd_q    <= col_rd_d;
      wr_slot_q   <= wr_slot_d;
      rd_slot_q   <= rd_slot_d;
      rows_full_q <= rows_full_d;
      rows_wr_q   <= rows_wr_d;
      rows_rd_q   <= rows_rd_d;
      state_q     <= state_d;
      win_q       <= win_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      intr_q      <= intr_d;
      done_q      <= done_d;
    end
  end

  assign bus.window_data  = win_q;
  assign bus.window_valid = valid_q;
  assign bus.intr         = intr_q;
  assign bus.frame_done   = done_q;
endmodule
